// File: rtl/sort_stream.sv
// Collects an 8-byte frame, sorts it ascending with an 8-phase odd-even
// transposition network (one phase per cycle), then streams it out.
//
// state   | meaning
// --------+-----------------------------------------------
// S_LOAD  | accepting input bytes into slot[cnt]
// S_SORT  | one compare-exchange phase per cycle, 8 phases
// S_DRAIN | presenting slot[idx] downstream until accepted
module sort_stream (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SORT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [2:0] r_phase;
    logic [2:0] r_idx;
    logic [7:0] r_slot [8];

    logic [7:0] w_sorted [8];
    logic       w_in_xfer;
    logic       w_out_xfer;

    // Even phases pair (0,1)..(6,7); odd phases pair (1,2)..(5,6).
    always_comb begin
        w_sorted = r_slot;
        for (int p = 0; p < 7; p++) begin
            if ((p[0] == r_phase[0]) && (r_slot[p] > r_slot[p+1])) begin
                w_sorted[p]   = r_slot[p+1];
                w_sorted[p+1] = r_slot[p];
            end
        end
    end

    assign in_ready   = !rst && (r_state == S_LOAD);
    assign out_valid  = !rst && (r_state == S_DRAIN);
    assign busy       = !rst && (r_state != S_LOAD);
    assign out_data   = out_valid ? r_slot[r_idx] : 8'h00;
    assign out_last   = out_valid && (r_idx == 3'd7);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_cnt   <= 3'd0;
            r_phase <= 3'd0;
            r_idx   <= 3'd0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_xfer) begin
                        r_slot[r_cnt] <= in_data;
                        r_cnt         <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state <= S_SORT;
                            r_phase <= 3'd0;
                        end
                    end
                end
                S_SORT: begin
                    r_slot  <= w_sorted;
                    r_phase <= r_phase + 3'd1;
                    if (r_phase == 3'd7) begin
                        r_state <= S_DRAIN;
                        r_idx   <= 3'd0;
                    end
                end
                S_DRAIN: begin
                    if (w_out_xfer) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_LOAD;
                            r_cnt   <= 3'd0;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_stream.sv
// Directed bench for sort_stream: frames are loaded, the expected sorted
// sequence is queued, and drained values are compared against the queue.
module tb_sort_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] frame [8];

    sort_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference sort: plain insertion sort, independent of the DUT network.
    task automatic push_expected(input logic [7:0] v [8]);
        logic [7:0] s [8];
        logic [7:0] t;
        s = v;
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j-1] > s[j]) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
    endtask

    task automatic load_frame(input logic [7:0] v [8], input bit gaps);
        int i = 0;
        int budget = 0;
        bit acc;
        while (i < 8 && budget < 200) begin
            in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = in_valid ? v[i] : 8'($urandom);
            acc = in_valid && in_ready;
            if (budget == 0) chk("load_in_ready", in_ready, 1);
            tick();
            if (acc) i++;
            budget++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (i != 8) chk("load_timeout", i, 8);
        chk("sort_busy", busy, 1);
        chk("sort_in_ready", in_ready, 0);
    endtask

    task automatic drain(input int stall_at, input int stall_len);
        logic [7:0] exp;
        int wait_cnt;
        for (int k = 0; k < 8; k++) begin
            wait_cnt = 0;
            while (!out_valid && wait_cnt < 20) begin
                tick();
                wait_cnt++;
            end
            if (!out_valid) begin
                chk("drain_timeout", out_valid, 1);
                return;
            end
            if (exp_q.size() == 0) begin
                chk("queue_empty", exp_q.size(), 1);
                return;
            end
            exp = exp_q.pop_front();
            if (k == stall_at) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 8'hAA;
                for (int s = 0; s < stall_len; s++) begin
                    chk("stall_data", out_data, exp);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_in_ready", in_ready, 0);
                    tick();
                end
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            chk("out_data", out_data, exp);
            chk("out_last", out_last, (k == 7));
            chk("drain_busy", busy, 1);
            tick();
        end
        chk("post_frame_in_ready", in_ready, 1);
        chk("post_frame_out_valid", out_valid, 0);
        chk("post_frame_out_data", out_data, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Descending frame with latency measurement.
        frame = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        push_expected(frame);
        load_frame(frame, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            if (j < 8) chk("latency_early", out_valid, 0);
            tick();
        end
        chk("latency_valid", out_valid, 1);
        drain(-1, 0);

        // Full-range values, downstream stall at index 3.
        frame = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h80, 8'h00};
        push_expected(frame);
        load_frame(frame, 1'b0);
        drain(3, 5);

        // Random values with random input gaps.
        for (int i = 0; i < 8; i++) frame[i] = 8'($urandom);
        push_expected(frame);
        load_frame(frame, 1'b1);
        drain(-1, 0);

        // Abort a frame in SORT phase 4; nothing of it may appear later.
        frame = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd204, 8'd205, 8'd206, 8'd207};
        load_frame(frame, 1'b0);
        for (int j = 0; j < 4; j++) tick();
        rst = 1'b1;
        #1;
        chk("midsort_rst_in_ready", in_ready, 0);
        chk("midsort_rst_busy", busy, 0);
        chk("midsort_rst_out_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("midsort_post_in_ready", in_ready, 1);
        frame = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        push_expected(frame);
        load_frame(frame, 1'b0);
        drain(-1, 0);

        // Two frames back-to-back.
        frame = '{8'd9, 8'd9, 8'd3, 8'd250, 8'd0, 8'd9, 8'd128, 8'd127};
        push_expected(frame);
        load_frame(frame, 1'b0);
        drain(-1, 0);
        frame = '{8'd5, 8'd4, 8'd255, 8'd4, 8'd16, 8'd1, 8'd0, 8'd99};
        push_expected(frame);
        load_frame(frame, 1'b0);
        drain(-1, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
